// File: rtl/onehot_opcode_encoder.sv
// Sequential 64-to-6 encoder: streams the index of every set mask bit,
// lowest first, one per handshake; inverse of the opcode decoder.
module onehot_opcode_encoder #(
  parameter int N  = 64,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  mask,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] code,
  output logic          last,
  output logic          done
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic           done_q, done_d;
  logic [CW-1:0]  enc;
  logic           single;

  // x & (x-1) clears the lowest set bit; zero result means one bit left
  assign single = (pend_q != '0) &&
                  ((pend_q & (pend_q - N'(1))) == '0);

  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) enc = CW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mask != '0) begin
            pend_d  = mask;
            state_d = EMIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_d = pend_q & (pend_q - N'(1));
          if (single) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !reset;
    out_valid = (state_q == EMIT);
    code      = enc;
    last      = out_valid && single;
    done      = done_q;
  end

endmodule

// File: tb/tb_onehot_opcode_encoder.sv
// Scoreboard bench for onehot_opcode_encoder: expected codes queued
// at load time, popped on each output handshake.
module tb_onehot_opcode_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] mask = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  code;
  logic        last;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] sb[$];

  onehot_opcode_encoder #(.N(64), .CW(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code      (code),
    .last      (last),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input logic rdy);
    logic [6:0] e;
    out_ready = rdy;
    if (out_valid && rdy) begin
      if (sb.size() == 0) begin
        chk("spurious", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("code", 64'(code), 64'(e[5:0]));
        chk("last", 64'(last), 64'(e[6]));
      end
    end
    tick();
  endtask

  task automatic load(input logic [63:0] m, input bit autopush);
    int hi;
    chk("ld_rdy", 64'(in_ready), 1);
    hi = -1;
    for (int i = 0; i < 64; i++) if (m[i]) hi = i;
    if (autopush) begin
      for (int i = 0; i < 64; i++)
        if (m[i]) sb.push_back({(i == hi), 6'(i)});
    end
    in_valid = 1'b1;
    mask     = m;
    tick();
    in_valid = 1'b0;
    mask     = '0;
  endtask

  task automatic drain(input int exp_cyc);
    int c;
    c = 0;
    while (sb.size() != 0 && c < 200) begin
      run_cycle(1'b1);
      c++;
    end
    chk("drain_left", 64'(sb.size()), 0);
    if (exp_cyc > 0) chk("drain_cyc", 64'(c), 64'(exp_cyc));
    chk("done_pulse", 64'(done), 1);
    chk("rdy_again", 64'(in_ready), 1);
    chk("ov_idle", 64'(out_valid), 0);
    out_ready = 1'b0;
    tick();
    chk("done_clr", 64'(done), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ov"},   64'(out_valid), 0);
    chk({tag, "_code"}, 64'(code), 0);
    chk({tag, "_last"}, 64'(last), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_ir"},   64'(in_ready), 0);
  endtask

  initial begin
    logic [5:0] ops [5];
    ops[0] = 6'b100000;
    ops[1] = 6'b100111;
    ops[2] = 6'b100011;
    ops[3] = 6'b101011;
    ops[4] = 6'b000100;

    tick();
    tick();
    chk_zero("rst");
    reset = 1'b0;
    #1;
    chk("rst_rel_ir", 64'(in_ready), 1);

    // single low bit
    load(64'h1, 1);
    chk("m1_ov", 64'(out_valid), 1);
    drain(1);

    // sparse mask, back to back codes
    load(64'h8000_0000_0000_0009, 1);
    drain(3);

    // stall with ignored in_valid
    load(64'h0000_0000_0000_00A0, 1);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      mask     = '1;
      chk("st_ir", 64'(in_ready), 0);
      chk("st_ov", 64'(out_valid), 1);
      chk("st_code", 64'(code), 5);
      chk("st_last", 64'(last), 0);
      run_cycle(1'b0);
    end
    in_valid = 1'b0;
    mask     = '0;
    drain(2);

    // zero mask
    load(64'h0, 1);
    chk("z_ov", 64'(out_valid), 0);
    chk("z_done", 64'(done), 1);
    chk("z_ir", 64'(in_ready), 1);
    tick();
    chk("z_done_clr", 64'(done), 0);

    // decoder round trip
    for (int k = 0; k < 5; k++) begin
      sb.push_back({1'b1, ops[k]});
      load(64'h1 << ops[k], 0);
      drain(1);
    end

    // reset mid-stream
    load('1, 1);
    for (int k = 0; k < 10; k++) run_cycle(1'b1);
    reset = 1'b1;
    #1;
    chk_zero("mid");
    sb.delete();
    tick();
    chk_zero("mid2");
    reset = 1'b0;
    #1;
    chk("post_ir", 64'(in_ready), 1);
    chk("post_ov", 64'(out_valid), 0);
    load(64'h4, 1);
    chk("post_code", 64'(code), 2);
    drain(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
